usb_mailbox: RTL and testbench
==============================

# usb_mailbox

Byte-level register and FIFO bridge directly downstream of `usb_driver`. It receives the decoded host transactions (address write, data write, data read) as single-cycle pulses. It maps them onto a small register file and exposes two byte FIFOs to the CPU side: host→CPU (rx) and CPU→host (tx). It also returns read data to `usb_driver` for the host's data-read cycles.

## Interface
Parameters:
- `DEPTH_LOG2`, default 3: log2 of each FIFO's depth (8 entries).

Ports:
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `addr_we`  in  1  one-cycle pulse: host address write; `host_wdata` carries the address.
- `data_we`  in  1  one-cycle pulse: host data write to the current address.
- `data_re`  in  1  one-cycle pulse: host data read from the current address.
- `host_wdata`  in  8  byte from `usb_driver`.
- `host_rdata`  out  8  read result, registered.
- `host_rvalid`  out  1  one-cycle pulse; `host_rdata` is valid in that cycle.
- `rx_data`  out  8  head of the rx FIFO (first-word fall-through).
- `rx_valid`  out  1  rx FIFO is non-empty.
- `rx_ready`  in  1  CPU pops rx when `rx_valid && rx_ready`.
- `tx_data`  in  8  byte from the CPU.
- `tx_valid`  in  1  CPU pushes tx when `tx_valid && tx_ready`.
- `tx_ready`  out  1  tx FIFO is not full.

## Operation
- The address register is 8 bits and resets to 0x00. `addr_we` loads it from `host_wdata`. There is no auto-increment.
- Register map:
  - 0x00 DATA
    - Write: pushes to rx. If rx is full with no CPU pop in the same cycle, the byte is dropped and `ovf` is set.
    - Read: pops tx. If tx is empty, the read returns 0x00 and sets `unf`.
  - 0x01 STATUS
    - Read bits: bit0 `rx_full`, bit1 `rx_empty`, bit2 `tx_full`, bit3 `tx_empty`, bit4 `ovf`, bit5 `unf`, bits7:6 = 0.
    - Write: 1-to-clear on bits 4 and 5; all other bits are ignored.
  - 0x02 RX_COUNT: read-only, zero-extended rx occupancy.
  - 0x03 TX_COUNT: read-only, zero-extended tx occupancy.
  - Any other address reads 0xFF; writes are ignored.
- `usb_driver` guarantees at most one of `addr_we`, `data_we`, `data_re` per cycle. If more than one is asserted, priority is `addr_we` > `data_we` > `data_re`, and the lower-priority pulses are discarded.
- FIFO occupancy counts are `DEPTH_LOG2+1` bits wide, range 0..2^DEPTH_LOG2. Pointers are `DEPTH_LOG2` bits and wrap modulo depth.
- Simultaneous push and pop on one FIFO:
  - Both succeed and the count is unchanged.
  - This holds even when the FIFO is full, because the pop frees the slot.
  - When empty, only the push takes effect and the pop is ignored.
- Reset values:
  - Both FIFOs empty.
  - `ovf` = `unf` = 0.
  - `host_rdata` = 0x00, `host_rvalid` = 0.
  - `rx_valid` = 0, `rx_data` = don't-care.
  - `tx_ready` = 1.
- Reset asserted mid-transaction aborts the transaction. No `host_rvalid` is produced for a `data_re` pulse that falls in the reset cycle.

## Timing
- `data_re` in cycle N produces `host_rvalid` = 1 and `host_rdata` in cycle N+1.
  - The tx pop and any `unf` set are registered at the end of cycle N.
  - STATUS and COUNT reads sample state as of cycle N, before that cycle's updates.
- `data_we` to DATA in cycle N:
  - `rx_valid` rises in N+1 if rx was empty.
  - RX_COUNT reflects the push from N+1.
- CPU rx pop in cycle N: the next head appears on `rx_data` in N+1.
- CPU tx push in cycle N: the byte is readable by a host `data_re` in N+1 or later.
- `tx_ready` and `rx_valid` are functions of registered counts only, with no combinational path from `tx_valid` or `rx_ready`.
- `addr_we` in cycle N: the new address applies to a `data_we`/`data_re` in N+1.

## Structure
- Register addresses 0x00–0x03 and STATUS bit indices go in the shared `parameters.vh` so that the CPU-side software header and the benches share them.
- Sub-module `sync_fifo` with parameters `WIDTH` (8) and `DEPTH_LOG2`:
  - Ports: push, pop, din, dout (fall-through), count, full, empty.
  - Instantiated twice, once for rx and once for tx.
- `usb_mailbox` contains the address register, the read mux, the flags and the push/pop steering.

## Test plan
- Reset, then read STATUS (write addr 0x01, `data_re`) → `host_rdata` = 0x0A (`rx_empty`, `tx_empty`), `host_rvalid` one cycle after `data_re`.
- Addr 0x00, host writes 0x6A, 0x11, 0x22 → `rx_valid` = 1 with `rx_data` 0x6A, 0x11, 0x22 in order as the CPU pops with `rx_ready`; RX_COUNT reads 3 before the pops and 0 after.
- Nine host writes with `rx_ready` = 0 → the first 8 are stored; STATUS = 0x19 (`rx_full`, `tx_empty`, `ovf`). Writing 0x10 to STATUS clears `ovf`, after which STATUS = 0x09.
- Fill rx to full, then in the same cycle `data_we` 0x55 and CPU pop → count stays 8, nothing is dropped, and 0x55 is the last byte out.
- CPU pushes 0xA5, then the host reads addr 0x00 twice → first read 0xA5, second read 0x00 with `unf` set (STATUS bit5).
- Assert `reset` in the cycle of a `data_re` after filling both FIFOs → no `host_rvalid`; FIFOs empty, `tx_ready` = 1, address 0x00.

Source files
------------

// File: rtl/usb_mailbox_pkg.sv
// Shared register map and STATUS bit layout for the usb_mailbox host/CPU bridge.
package usb_mailbox_pkg;

  localparam logic [7:0] AddrData    = 8'h00;
  localparam logic [7:0] AddrStatus  = 8'h01;
  localparam logic [7:0] AddrRxCount = 8'h02;
  localparam logic [7:0] AddrTxCount = 8'h03;

  localparam int unsigned StatRxFull  = 0;
  localparam int unsigned StatRxEmpty = 1;
  localparam int unsigned StatTxFull  = 2;
  localparam int unsigned StatTxEmpty = 3;
  localparam int unsigned StatOvf     = 4;
  localparam int unsigned StatUnf     = 5;

  localparam logic [7:0] UnmappedRead = 8'hFF;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word fall-through FIFO; a pop frees a slot for a same-cycle push.
module sync_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [Depth];
  logic [DEPTH_LOG2-1:0] wptr_q, rptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (DEPTH_LOG2 + 1)'(Depth));
  assign count   = count_q;
  assign dout    = mem[rptr_q];
  assign pop_ok  = pop && !empty;
  // An empty FIFO ignores the pop, so a push then only lands if there is room.
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr_q] <= din;
  end

endmodule

// File: rtl/usb_mailbox.sv
// Host register file and rx/tx byte FIFOs between usb_driver and the CPU.
module usb_mailbox
  import usb_mailbox_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       addr_we,
  input  logic       data_we,
  input  logic       data_re,
  input  logic [7:0] host_wdata,
  output logic [7:0] host_rdata,
  output logic       host_rvalid,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready
);

  logic [7:0]          addr_q;
  logic [7:0]          host_rdata_q;
  logic                host_rvalid_q;
  logic                ovf_q, unf_q;

  logic                do_wr, do_rd;
  logic                rx_push, rx_full, rx_empty;
  logic                tx_push, tx_pop, tx_full, tx_empty;
  logic [DEPTH_LOG2:0] rx_count, tx_count;
  logic [7:0]          tx_dout;
  logic [7:0]          rd_data;
  logic [7:0]          status;

  // addr_we outranks data_we, which outranks data_re.
  assign do_wr = data_we && !addr_we;
  assign do_rd = data_re && !addr_we && !data_we;

  assign rx_push = do_wr && (addr_q == AddrData);
  assign tx_pop  = do_rd && (addr_q == AddrData);
  assign tx_push = tx_valid && tx_ready;

  assign rx_valid    = !rx_empty;
  assign tx_ready    = !tx_full;
  assign host_rdata  = host_rdata_q;
  assign host_rvalid = host_rvalid_q;

  sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .pop   (rx_ready),
    .din   (host_wdata),
    .dout  (rx_data),
    .count (rx_count),
    .full  (rx_full),
    .empty (rx_empty)
  );

  sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (tx_data),
    .dout  (tx_dout),
    .count (tx_count),
    .full  (tx_full),
    .empty (tx_empty)
  );

  always_comb begin
    status              = 8'h00;
    status[StatRxFull]  = rx_full;
    status[StatRxEmpty] = rx_empty;
    status[StatTxFull]  = tx_full;
    status[StatTxEmpty] = tx_empty;
    status[StatOvf]     = ovf_q;
    status[StatUnf]     = unf_q;
  end

  always_comb begin
    rd_data = UnmappedRead;
    case (addr_q)
      AddrData:    rd_data = tx_empty ? 8'h00 : tx_dout;
      AddrStatus:  rd_data = status;
      AddrRxCount: rd_data = 8'(rx_count);
      AddrTxCount: rd_data = 8'(tx_count);
      default:     rd_data = UnmappedRead;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q        <= 8'h00;
      host_rdata_q  <= 8'h00;
      host_rvalid_q <= 1'b0;
      ovf_q         <= 1'b0;
      unf_q         <= 1'b0;
    end else begin
      host_rvalid_q <= do_rd;
      if (do_rd) host_rdata_q <= rd_data;
      if (addr_we) addr_q <= host_wdata;
      // A full rx only accepts the byte when the CPU frees a slot this cycle.
      if (rx_push && rx_full && !rx_ready) ovf_q <= 1'b1;
      if (tx_pop && tx_empty) unf_q <= 1'b1;
      if (do_wr && (addr_q == AddrStatus)) begin
        if (host_wdata[StatOvf]) ovf_q <= 1'b0;
        if (host_wdata[StatUnf]) unf_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_usb_mailbox.sv
// Directed bench for usb_mailbox: register reads, FIFO ordering, overflow/underflow, reset abort.
module tb_usb_mailbox;

  logic       clk = 1'b0;
  logic       reset;
  logic       addr_we, data_we, data_re;
  logic [7:0] host_wdata;
  logic [7:0] host_rdata;
  logic       host_rvalid;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  usb_mailbox #(
    .DEPTH_LOG2 (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .addr_we     (addr_we),
    .data_we     (data_we),
    .data_re     (data_re),
    .host_wdata  (host_wdata),
    .host_rdata  (host_rdata),
    .host_rvalid (host_rvalid),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_addr(input logic [7:0] a);
    addr_we = 1'b1; host_wdata = a;
    tick();
    addr_we = 1'b0;
  endtask

  task automatic host_write(input logic [7:0] d);
    data_we = 1'b1; host_wdata = d;
    tick();
    data_we = 1'b0;
  endtask

  task automatic host_read(input string tag, input logic [7:0] exp);
    data_re = 1'b1;
    tick();
    data_re = 1'b0;
    check({tag, "_rvalid"}, 32'(host_rvalid), 32'd1);
    check(tag, 32'(host_rdata), 32'(exp));
  endtask

  logic [7:0] drain_exp [8];

  initial begin
    reset = 1'b1; addr_we = 1'b0; data_we = 1'b0; data_re = 1'b0;
    host_wdata = 8'h00; rx_ready = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_rvalid", 32'(host_rvalid), 32'd0);
    check("rst_rdata", 32'(host_rdata), 32'h00);

    host_addr(8'h01);
    host_read("status_reset", 8'h0A);
    tick();
    check("rvalid_one_cycle", 32'(host_rvalid), 32'd0);

    // Three bytes host -> CPU
    host_addr(8'h00);
    host_write(8'h6A); host_write(8'h11); host_write(8'h22);
    host_addr(8'h02);
    host_read("rx_count3", 8'h03);
    check("rx_valid3", 32'(rx_valid), 32'd1);
    check("rx_head0", 32'(rx_data), 32'h6A);
    rx_ready = 1'b1;
    tick();
    check("rx_head1", 32'(rx_data), 32'h11);
    tick();
    check("rx_head2", 32'(rx_data), 32'h22);
    tick();
    rx_ready = 1'b0;
    check("rx_drained", 32'(rx_valid), 32'd0);
    host_read("rx_count0", 8'h00);

    // Overflow: nine writes into an 8-deep rx
    host_addr(8'h00);
    for (int i = 0; i < 9; i++) host_write(8'h30 + 8'(i));
    host_addr(8'h01);
    host_read("status_ovf", 8'h19);
    host_write(8'h10);
    host_read("status_ovf_clr", 8'h09);

    // Full rx: simultaneous host push and CPU pop
    host_addr(8'h00);
    data_we = 1'b1; host_wdata = 8'h55; rx_ready = 1'b1;
    tick();
    data_we = 1'b0; rx_ready = 1'b0;
    check("full_pushpop_head", 32'(rx_data), 32'h31);
    host_addr(8'h02);
    host_read("full_pushpop_count", 8'h08);
    host_addr(8'h01);
    host_read("full_pushpop_status", 8'h09);
    for (int i = 0; i < 7; i++) drain_exp[i] = 8'h31 + 8'(i);
    drain_exp[7] = 8'h55;
    rx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d", i), 32'(rx_data), 32'(drain_exp[i]));
      tick();
    end
    rx_ready = 1'b0;
    check("drain_empty", 32'(rx_valid), 32'd0);

    // CPU -> host, then underflow
    tx_valid = 1'b1; tx_data = 8'hA5;
    tick();
    tx_valid = 1'b0;
    host_addr(8'h03);
    host_read("tx_count1", 8'h01);
    host_addr(8'h00);
    host_read("tx_read_a5", 8'hA5);
    host_read("tx_read_empty", 8'h00);
    host_addr(8'h01);
    host_read("status_unf", 8'h2A);
    host_write(8'h20);
    host_read("status_unf_clr", 8'h0A);
    host_addr(8'h07);
    host_read("unmapped", 8'hFF);

    // Fill both FIFOs, then reset during a data_re
    for (int i = 0; i < 9; i++) begin
      tx_valid = 1'b1; tx_data = 8'hC0 + 8'(i);
      tick();
    end
    tx_valid = 1'b0;
    check("tx_full_ready", 32'(tx_ready), 32'd0);
    host_addr(8'h03);
    host_read("tx_count8", 8'h08);
    host_addr(8'h00);
    for (int i = 0; i < 8; i++) host_write(8'h80 + 8'(i));
    check("rx_full_valid", 32'(rx_valid), 32'd1);
    data_re = 1'b1; reset = 1'b1;
    tick();
    data_re = 1'b0; reset = 1'b0;
    check("rst_abort_rvalid", 32'(host_rvalid), 32'd0);
    check("rst_abort_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_abort_tx_ready", 32'(tx_ready), 32'd1);
    tick();
    check("rst_abort_rvalid_late", 32'(host_rvalid), 32'd0);
    // Address must be back at DATA: a write with no address load lands in rx.
    host_write(8'h77);
    check("rst_addr_rx_valid", 32'(rx_valid), 32'd1);
    check("rst_addr_rx_data", 32'(rx_data), 32'h77);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
